spike_rate_decoder: RTL
=======================

// Module: spike_rate_decoder
// PURPOSE
//   Receive-side counterpart of the LIF neuron: converts a 1-bit spike train back
//   into an unsigned rate word. Spikes are sampled on slow tick cycles, counted
//   over a fixed window of 2^WINDOW_LOG2 ticks and published with a 1-cycle strobe.
//   Sits after the neuron in the TT top level, sharing its tick (divider terminal count).
// PARAMETERS
//   WINDOW_LOG2   8   log2 of window length in ticks; legal range 1..16
//   CNT_W         8   width of spike counter and rate output
//   SMOOTH_SHIFT  2   EMA shift; used only when RATE_SMOOTH_EN is defined; range 1..CNT_W-1
// PORTS
//   clk        in   1            clock, rising edge
//   rst_n      in   1            reset, asynchronous, active low
//   tick       in   1            sample enable; 1-cycle pulse, may be high every cycle
//   spike      in   1            spike level from neuron; sampled only when tick=1
//   clear      in   1            synchronous restart of the current window
//   rate       out  CNT_W        last published spike count (or smoothed value)
//   rate_valid out  1            1-cycle strobe, high the cycle after rate updates
//   rate_sat   out  1            published window saturated the counter
//   win_phase  out  WINDOW_LOG2  current tick index within the window
// BEHAVIOUR
//   Reset (rst_n=0, async): all counters, rate, rate_valid, rate_sat, win_phase,
//     primed flag = 0 immediately; mid-window reset discards the partial window.
//   Priority per edge: clear > tick > hold.
//   clear=1: win_phase, spike count and in-window sat flag <= 0; rate and rate_sat
//     hold; primed <= 0; any tick in the same cycle is ignored; rate_valid <= 0.
//   tick=1, clear=0: win_phase <= win_phase+1 (wraps to 0 after 2^WINDOW_LOG2-1);
//     if spike=1, count <= count+1, saturating at 2^CNT_W-1 and setting the in-window sat flag.
//   Last tick (win_phase = all ones, tick=1, clear=0): final = saturating
//     count+spike; rate <= final; rate_sat <= sat flag OR (count+spike overflowed);
//     count and sat flag <= 0; win_phase wraps to 0; primed <= 1.
//   rate_valid: registered; 1 for exactly the one cycle after a last-tick edge,
//     0 otherwise; back-to-back valids impossible unless WINDOW_LOG2=1 with tick
//     every cycle, in which case valid is high on alternate cycles.
//   tick=0: all state holds; spike ignored.
//   Latency: rate visible one clock after the edge sampling the final tick.
//   Saturation: count never wraps; 2^WINDOW_LOG2 spikes with CNT_W=8,
//     WINDOW_LOG2=8 publish 255 with rate_sat=1.
//   spike held high across several ticks counts once per tick (level, not edge).
// CONFIGURATION
//   RATE_SMOOTH_EN defined: at last tick, if primed=0, rate <= final (direct load);
//     else rate <= rate + ((final - rate) >>> SMOOTH_SHIFT) in signed CNT_W+1
//     arithmetic (arithmetic shift truncates toward -inf), result clamped to 0..2^CNT_W-1.
//     rate_sat reflects the raw window only. clear and reset zero primed, so the
//     next window loads directly.
//   RATE_SMOOTH_EN undefined: rate <= final every window; no primed logic or
//     smoothing datapath is synthesized; SMOOTH_SHIFT is unused.
// TESTING
//   T1 reset: drive rst_n=0 mid-window with count=5 -> rate=0, rate_valid=0,
//      rate_sat=0, win_phase=0 with no clock edge; first window after release starts at 0.
//   T2 WINDOW_LOG2=4, spike=1, tick every 4th cycle -> after 16 ticks rate=16,
//      rate_valid high exactly 1 cycle, rate_sat=0; spike=1 with tick=0 adds nothing.
//   T3 WINDOW_LOG2=8, CNT_W=8, spike=1, tick every cycle -> rate=255, rate_sat=1;
//      next window with spike=0 -> rate=0, rate_sat=0.
//   T4 WINDOW_LOG2=4, spike on ticks 0..4, clear with tick on tick 5 -> no valid;
//      following 16 ticks with 3 spikes -> rate=3; rate held old value during clear.
//   T5 WINDOW_LOG2=4, spike on alternate ticks, clear on last-tick cycle -> no
//      publish, win_phase=0, rate unchanged.
//   T6 RATE_SMOOTH_EN, SMOOTH_SHIFT=2, WINDOW_LOG2=4: windows of 16 then 0 spikes
//      -> rate=16 then 12; then 16 again -> 13.

Source files
------------

// File: rtl/spike_rate_decoder.sv
// Spike rate decoder: counts spikes sampled on tick cycles over a window of
// 2^WINDOW_LOG2 ticks and publishes the count with a one-cycle valid strobe.
// Optional feature macro: RATE_SMOOTH_EN (EMA smoothing of the published rate).
module spike_rate_decoder #(
  parameter int WINDOW_LOG2  = 8,
  parameter int CNT_W        = 8,
  parameter int SMOOTH_SHIFT = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   tick,
  input  logic                   spike,
  input  logic                   clear,
  output logic [CNT_W-1:0]       rate,
  output logic                   rate_valid,
  output logic                   rate_sat,
  output logic [WINDOW_LOG2-1:0] win_phase
);

  localparam logic [CNT_W-1:0]       CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [WINDOW_LOG2-1:0] PHASE_END = {WINDOW_LOG2{1'b1}};

  logic [CNT_W-1:0]       count_r;
  logic                   sat_r;
  logic [WINDOW_LOG2-1:0] phase_r;
  logic [CNT_W-1:0]       rate_r;
  logic                   rate_sat_r;
  logic                   valid_r;

  logic [CNT_W:0]   sum_s;
  logic             ovf_s;
  logic [CNT_W-1:0] final_s;
  logic             last_s;
  logic [CNT_W-1:0] next_rate_s;

  // Saturating count+spike; also the value published on the last tick
  always_comb begin
    sum_s   = {1'b0, count_r} + (CNT_W+1)'(spike);
    ovf_s   = sum_s[CNT_W];
    last_s  = (phase_r == PHASE_END);
    if (ovf_s) begin
      final_s = CNT_MAX;
    end else begin
      final_s = sum_s[CNT_W-1:0];
    end
  end

`ifdef RATE_SMOOTH_EN
  logic                 primed_r;
  logic signed [CNT_W:0]   diff_s;
  logic signed [CNT_W:0]   step_s;
  logic signed [CNT_W+1:0] ema_s;

  // EMA update in signed arithmetic; first window after reset/clear loads directly
  always_comb begin
    diff_s = $signed({1'b0, final_s}) - $signed({1'b0, rate_r});
    step_s = diff_s >>> SMOOTH_SHIFT;
    ema_s  = $signed({2'b00, rate_r}) + $signed({step_s[CNT_W], step_s});
    if (!primed_r) begin
      next_rate_s = final_s;
    end else if (ema_s[CNT_W+1]) begin
      next_rate_s = {CNT_W{1'b0}};
    end else if (ema_s[CNT_W]) begin
      next_rate_s = CNT_MAX;
    end else begin
      next_rate_s = ema_s[CNT_W-1:0];
    end
  end

  // Primed flag: set once a full window has been published since reset/clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      primed_r <= 1'b0;
    end else if (clear) begin
      primed_r <= 1'b0;
    end else if (tick && last_s) begin
      primed_r <= 1'b1;
    end else begin
      primed_r <= primed_r;
    end
  end
`else
  // Without smoothing the raw window count is published directly
  always_comb begin
    next_rate_s = final_s;
  end
`endif

  // Window counter, spike counter and publish registers (clear > tick > hold)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r    <= {CNT_W{1'b0}};
      sat_r      <= 1'b0;
      phase_r    <= {WINDOW_LOG2{1'b0}};
      rate_r     <= {CNT_W{1'b0}};
      rate_sat_r <= 1'b0;
      valid_r    <= 1'b0;
    end else if (clear) begin
      count_r <= {CNT_W{1'b0}};
      sat_r   <= 1'b0;
      phase_r <= {WINDOW_LOG2{1'b0}};
      valid_r <= 1'b0;
    end else if (tick) begin
      phase_r <= phase_r + WINDOW_LOG2'(1);
      if (last_s) begin
        rate_r     <= next_rate_s;
        rate_sat_r <= sat_r | ovf_s;
        count_r    <= {CNT_W{1'b0}};
        sat_r      <= 1'b0;
        valid_r    <= 1'b1;
      end else begin
        count_r <= final_s;
        sat_r   <= sat_r | ovf_s;
        valid_r <= 1'b0;
      end
    end else begin
      valid_r <= 1'b0;
    end
  end

  assign rate       = rate_r;
  assign rate_valid = valid_r;
  assign rate_sat   = rate_sat_r;
  assign win_phase  = phase_r;

endmodule
